dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl_pkg.sv | 15 +
 rtl/dcache_ctrl.sv | 135 +++++++++++++
 tb/tb_dcache_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared geometry defaults and controller state encoding
package dcache_ctrl_pkg;

   localparam int DBLOCK_SIZE     = 32;
   localparam int DSET_INDEX_SIZE = 5;
   localparam int DTAG_SIZE       = 32 - DSET_INDEX_SIZE - $clog2(DBLOCK_SIZE);

   typedef enum logic [1:0] {
      DCTRL_IDLE    = 2'd0,
      DCTRL_WB      = 2'd1,
      DCTRL_REFILL  = 2'd2,
      DCTRL_INSTALL = 2'd3
   } dctrl_state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - data-cache sequencer: hit path, dirty writeback, refill, install
// and replay, plus wrapping hit/miss counters.
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BLOCK_BYTES = DBLOCK_SIZE,
   parameter int INDEX_W     = DSET_INDEX_SIZE,
   localparam int OFF_W      = $clog2(BLOCK_BYTES),
   localparam int TAG_W      = ADDR_W - INDEX_W - OFF_W,
   localparam int BB         = 8 * BLOCK_BYTES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_ren,
   input  logic                     cpu_wen,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [31:0]              cpu_wdata,
   input  logic [3:0]               cpu_be,
   output logic [31:0]              cpu_rdata,
   output logic                     cpu_stall,
   output logic                     sram_ren,
   output logic                     sram_wen,
   output logic                     sram_memWen,
   output logic [TAG_W+INDEX_W-1:0] sram_blockAddr,
   output logic [BLOCK_BYTES-1:0]   sram_bytesAccess,
   output logic [BB-1:0]            sram_dataIn,
   input  logic                     sram_hit,
   input  logic                     sram_dirty,
   input  logic [BB-1:0]            sram_dataOut,
   input  logic [TAG_W-1:0]         sram_victimTag,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [BB-1:0]            mem_wdata,
   input  logic [BB-1:0]            mem_rdata,
   input  logic                     mem_ack,
   output logic [31:0]              hit_cnt,
   output logic [31:0]              miss_cnt
);

   dctrl_state_t       state;
   logic [BB-1:0]      line_buf;
   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_index;
   logic               replay;

   logic [TAG_W-1:0]   cpu_tag;
   logic [INDEX_W-1:0] cpu_index;
   logic [OFF_W-1:0]   word_sel;
   logic               req;
   logic               in_idle;
   logic               in_install;

   assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
   assign cpu_index  = cpu_addr[OFF_W +: INDEX_W];
   assign word_sel   = cpu_addr[OFF_W-1:0] >> 2;
   assign req        = cpu_ren | cpu_wen;
   assign in_idle    = (state == DCTRL_IDLE);
   assign in_install = (state == DCTRL_INSTALL);

   // The array sees CPU traffic only in IDLE; during a miss it is addressed by the latched request.
   assign sram_ren         = in_idle & cpu_ren & ~cpu_wen;
   assign sram_wen         = in_idle & cpu_wen;
   assign sram_blockAddr   = in_idle ? {cpu_tag, cpu_index} : {req_tag, req_index};
   assign sram_bytesAccess = in_install ? {BLOCK_BYTES{1'b1}}
                           : in_idle    ? (BLOCK_BYTES'(cpu_be) << {word_sel, 2'b00})
                           : {BLOCK_BYTES{1'b0}};
   assign sram_dataIn      = in_install ? line_buf : {(BLOCK_BYTES/4){cpu_wdata}};
   assign cpu_rdata        = sram_dataOut[{word_sel, 5'b00000} +: 32];
   assign cpu_stall        = ~in_idle | (req & ~sram_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= DCTRL_IDLE;
         hit_cnt     <= 32'd0;
         miss_cnt    <= 32'd0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         sram_memWen <= 1'b0;
         line_buf    <= '0;
         req_tag     <= '0;
         req_index   <= '0;
         replay      <= 1'b0;
      end else begin
         case (state)
            DCTRL_IDLE: begin
               replay <= 1'b0;
               if (req && sram_hit) begin
                  if (!replay) hit_cnt <= hit_cnt + 32'd1;
               end else if (req) begin
                  miss_cnt  <= miss_cnt + 32'd1;
                  req_tag   <= cpu_tag;
                  req_index <= cpu_index;
                  mem_req   <= 1'b1;
                  if (sram_dirty) begin
                     state     <= DCTRL_WB;
                     mem_we    <= 1'b1;
                     mem_addr  <= {sram_victimTag, cpu_index, {OFF_W{1'b0}}};
                     mem_wdata <= sram_dataOut;
                  end else begin
                     state    <= DCTRL_REFILL;
                     mem_we   <= 1'b0;
                     mem_addr <= {cpu_tag, cpu_index, {OFF_W{1'b0}}};
                  end
               end
            end
            DCTRL_WB: begin
               if (mem_ack) begin
                  state    <= DCTRL_REFILL;
                  mem_we   <= 1'b0;
                  mem_addr <= {req_tag, req_index, {OFF_W{1'b0}}};
               end
            end
            DCTRL_REFILL: begin
               if (mem_ack) begin
                  state       <= DCTRL_INSTALL;
                  line_buf    <= mem_rdata;
                  mem_req     <= 1'b0;
                  sram_memWen <= 1'b1;
               end
            end
            DCTRL_INSTALL: begin
               state       <= DCTRL_IDLE;
               sram_memWen <= 1'b0;
               replay      <= 1'b1;
            end
            default: state <= DCTRL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed bench for dcache_ctrl with a direct-mapped array model
// and a main-memory responder with programmable ack delay.
module tb_dcache_ctrl;

   localparam int ADDR_W = 32;
   localparam int BLOCK_BYTES = 32;
   localparam int INDEX_W = 5;
   localparam int TAG_W = 22;
   localparam int BB = 256;

   logic clk = 1'b0;
   logic rst;
   logic cpu_ren, cpu_wen;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0] cpu_be;
   logic [31:0] cpu_rdata;
   logic cpu_stall;
   logic sram_ren, sram_wen, sram_memWen;
   logic [TAG_W+INDEX_W-1:0] sram_blockAddr;
   logic [BLOCK_BYTES-1:0] sram_bytesAccess;
   logic [BB-1:0] sram_dataIn, sram_dataOut, mem_wdata, mem_rdata;
   logic sram_hit, sram_dirty;
   logic [TAG_W-1:0] sram_victimTag;
   logic mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, hit_cnt, miss_cnt;

   int errors = 0;
   int checks = 0;

   dcache_ctrl #(.ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK_BYTES), .INDEX_W(INDEX_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
      .sram_blockAddr(sram_blockAddr), .sram_bytesAccess(sram_bytesAccess),
      .sram_dataIn(sram_dataIn), .sram_hit(sram_hit), .sram_dirty(sram_dirty),
      .sram_dataOut(sram_dataOut), .sram_victimTag(sram_victimTag),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Direct-mapped array model: one way per set, so the victim is the resident block.
   logic model_clr;
   logic [BB-1:0] arr_data [32];
   logic [TAG_W-1:0] arr_tag [32];
   logic arr_valid [32];
   logic arr_dirty [32];
   logic [4:0] m_idx;
   logic [TAG_W-1:0] m_tag;

   assign m_idx = sram_blockAddr[4:0];
   assign m_tag = sram_blockAddr[TAG_W+INDEX_W-1:INDEX_W];
   assign sram_hit = arr_valid[m_idx] && (arr_tag[m_idx] == m_tag);
   assign sram_dirty = arr_valid[m_idx] && arr_dirty[m_idx];
   assign sram_dataOut = arr_data[m_idx];
   assign sram_victimTag = arr_tag[m_idx];

   always @(posedge clk) begin
      if (model_clr) begin
         for (int s = 0; s < 32; s++) begin
            arr_data[s] <= '0;
            arr_tag[s] <= '0;
            arr_valid[s] <= 1'b0;
            arr_dirty[s] <= 1'b0;
         end
      end else if (sram_memWen) begin
         arr_data[m_idx] <= sram_dataIn;
         arr_tag[m_idx] <= m_tag;
         arr_valid[m_idx] <= 1'b1;
         arr_dirty[m_idx] <= 1'b0;
      end else if (sram_wen && sram_hit) begin
         for (int b = 0; b < BLOCK_BYTES; b++)
            if (sram_bytesAccess[b]) arr_data[m_idx][8*b +: 8] <= sram_dataIn[8*b +: 8];
         arr_dirty[m_idx] <= 1'b1;
      end
   end

   int memwen_cycles = 0;
   always @(posedge clk) if (sram_memWen) memwen_cycles <= memwen_cycles + 1;

   function automatic logic [BB-1:0] blk_pattern(input logic [31:0] a);
      logic [BB-1:0] r;
      for (int j = 0; j < 8; j++) r[32*j +: 32] = a + 32'(4 * j);
      return r;
   endfunction

   // Main-memory responder: ack on the ack_delay-th edge with mem_req high.
   logic [BB-1:0] mem_store [logic [31:0]];
   int ack_delay = 1;
   logic inject_ack = 1'b0;
   logic log_we [$];
   logic [31:0] log_addr [$];
   logic [BB-1:0] log_wdata [$];
   logic log_stable [$];

   initial begin
      int cnt;
      logic f_we, stable;
      logic [31:0] f_addr;
      logic [BB-1:0] f_wdata;
      cnt = 0; stable = 1'b1; f_we = 1'b0; f_addr = '0; f_wdata = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
         end
         if (inject_ack) begin
            mem_ack = 1'b1;
         end else if (mem_req) begin
            cnt++;
            if (cnt == 1) begin
               f_we = mem_we; f_addr = mem_addr; f_wdata = mem_wdata; stable = 1'b1;
            end else if (f_we !== mem_we || f_addr !== mem_addr || f_wdata !== mem_wdata) begin
               stable = 1'b0;
            end
            if (cnt == ack_delay) begin
               mem_ack = 1'b1;
               if (mem_we) mem_store[mem_addr] = mem_wdata;
               else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : blk_pattern(mem_addr);
               log_we.push_back(mem_we);
               log_addr.push_back(mem_addr);
               log_wdata.push_back(mem_wdata);
               log_stable.push_back(stable);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic clear_log();
      log_we.delete(); log_addr.delete(); log_wdata.delete(); log_stable.delete();
   endtask

   task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output int stalls, output logic [31:0] rdata,
                            output logic [BLOCK_BYTES-1:0] bytes_acc);
      stalls = 0;
      @(negedge clk);
      cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
      #1;
      while (cpu_stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      rdata = cpu_rdata;
      bytes_acc = sram_bytesAccess;
      @(posedge clk);
      #1;
      cpu_ren = 1'b0; cpu_wen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; model_clr = 1'b1;
      cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_clr = 1'b0;
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", cpu_stall); end
      checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
      checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem: got req=%b we=%b want 0 0", mem_req, mem_we); end
      checks++; if (sram_memWen !== 1'b0) begin errors++; $display("FAIL reset_memWen: got %b want 0", sram_memWen); end
      cpu_ren = 1'b1; cpu_addr = 32'h40;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_miss: got %b want 1", cpu_stall); end
      checks++; if (sram_ren !== 1'b1) begin errors++; $display("FAIL reset_sram_ren: got %b want 1", sram_ren); end
      cpu_ren = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_cold_store();
      int st, mw0; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba;
      clear_log(); ack_delay = 3; mw0 = memwen_cycles;
      do_access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, st, rd, ba);
      checks++; if (st != 5) begin errors++; $display("FAIL cold_stall_cycles: got %0d want 5", st); end
      checks++; if (log_addr.size() != 1 || log_addr[0] !== 32'h40 || log_we[0] !== 1'b0) begin
         errors++; $display("FAIL cold_refill_req: got n=%0d want one read of 0x40", log_addr.size()); end
      checks++; if (memwen_cycles - mw0 != 1) begin errors++; $display("FAIL cold_memWen_cycles: got %0d want 1", memwen_cycles - mw0); end
      checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
         errors++; $display("FAIL cold_counters: got miss=%0d hit=%0d want 1 0", miss_cnt, hit_cnt); end
      do_access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_readback: got stall=%0d data=%h want 0 deadbeef", st, rd); end
      checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL cold_readback_hits: got %0d want 1", hit_cnt); end
   endtask

   task automatic test_load_hit();
      int st; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba;
      do_access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 0 || rd !== 32'h44) begin errors++; $display("FAIL load_hit: got stall=%0d data=%h want 0 00000044", st, rd); end
      checks++; if (hit_cnt !== 32'd2) begin errors++; $display("FAIL load_hit_cnt: got %0d want 2", hit_cnt); end
   endtask

   task automatic test_byte_store();
      int st; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba; logic [BB-1:0] exp;
      do_access(1'b0, 1'b1, 32'h4C, 32'h0000AB00, 4'b0010, st, rd, ba);
      checks++; if (st != 0 || ba !== 32'h0000_2000) begin errors++; $display("FAIL byte_mask: got stall=%0d mask=%h want 0 00002000", st, ba); end
      exp = blk_pattern(32'h40);
      exp[31:0] = 32'hDEADBEEF;
      exp[127:96] = 32'h0000AB4C;
      checks++; if (arr_data[2] !== exp) begin errors++; $display("FAIL byte_block: got %h want %h", arr_data[2], exp); end
      do_access(1'b1, 1'b0, 32'h4C, 32'h0, 4'h0, st, rd, ba);
      checks++; if (rd !== 32'h0000AB4C) begin errors++; $display("FAIL byte_readback: got %h want 0000ab4c", rd); end
      checks++; if (hit_cnt !== 32'd4) begin errors++; $display("FAIL byte_hit_cnt: got %0d want 4", hit_cnt); end
   endtask

   task automatic test_writeback();
      int st; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba; logic [BB-1:0] exp;
      exp = blk_pattern(32'h40);
      exp[31:0] = 32'hDEADBEEF;
      exp[127:96] = 32'h0000AB4C;
      clear_log(); ack_delay = 2;
      do_access(1'b1, 1'b0, 32'h440, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 6) begin errors++; $display("FAIL wb_stall_cycles: got %0d want 6", st); end
      checks++; if (log_we.size() != 2) begin errors++; $display("FAIL wb_txn_count: got %0d want 2", log_we.size()); end
      else begin
         checks++; if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h40 || log_wdata[0] !== exp) begin
            errors++; $display("FAIL wb_write: got we=%b addr=%h want 1 00000040 with stored block", log_we[0], log_addr[0]); end
         checks++; if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h440) begin
            errors++; $display("FAIL wb_refill: got we=%b addr=%h want 0 00000440", log_we[1], log_addr[1]); end
      end
      checks++; if (rd !== 32'h440 || miss_cnt !== 32'd2 || hit_cnt !== 32'd4) begin
         errors++; $display("FAIL wb_result: got data=%h miss=%0d hit=%0d want 440 2 4", rd, miss_cnt, hit_cnt); end
   endtask

   task automatic test_long_refill();
      int st; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba;
      clear_log(); ack_delay = 11;
      do_access(1'b1, 1'b0, 32'h880, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 13) begin errors++; $display("FAIL long_stall_cycles: got %0d want 13", st); end
      checks++; if (log_stable.size() != 1 || log_stable[0] !== 1'b1) begin
         errors++; $display("FAIL long_req_stable: got n=%0d want one stable request", log_stable.size()); end
      checks++; if (rd !== 32'h880 || miss_cnt !== 32'd3) begin errors++; $display("FAIL long_result: got data=%h miss=%0d want 880 3", rd, miss_cnt); end
   endtask

   task automatic test_back_to_back();
      int st; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba;
      do_access(1'b1, 1'b0, 32'h444, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 0 || rd !== 32'h444) begin errors++; $display("FAIL b2b_first: got stall=%0d data=%h want 0 444", st, rd); end
      do_access(1'b1, 1'b0, 32'h448, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 0 || rd !== 32'h448) begin errors++; $display("FAIL b2b_second: got stall=%0d data=%h want 0 448", st, rd); end
      checks++; if (hit_cnt !== 32'd6) begin errors++; $display("FAIL b2b_hit_cnt: got %0d want 6", hit_cnt); end
   endtask

   task automatic test_stray_ack();
      int st, mw0; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba;
      clear_log(); mw0 = memwen_cycles;
      @(posedge clk); #1 inject_ack = 1'b1;
      @(posedge clk); #1 inject_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mem_req !== 1'b0 || memwen_cycles != mw0 || miss_cnt !== 32'd3 || hit_cnt !== 32'd6) begin
         errors++; $display("FAIL stray_ack_state: got req=%b memWen=%0d miss=%0d hit=%0d want 0 0 3 6", mem_req, memwen_cycles - mw0, miss_cnt, hit_cnt); end
      do_access(1'b1, 1'b0, 32'h448, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 0 || rd !== 32'h448 || hit_cnt !== 32'd7) begin
         errors++; $display("FAIL stray_ack_hit: got stall=%0d data=%h hit=%0d want 0 448 7", st, rd, hit_cnt); end
   endtask

   task automatic test_reset_mid_wb();
      int st, waited, mw0; logic [31:0] rd; logic [BLOCK_BYTES-1:0] ba; logic seen;
      do_access(1'b0, 1'b1, 32'h440, 32'h12345678, 4'hF, st, rd, ba);
      ack_delay = 20; mw0 = memwen_cycles; seen = 1'b0; waited = 0;
      @(negedge clk);
      cpu_ren = 1'b1; cpu_addr = 32'hC40;
      while (!seen && waited < 10) begin
         @(negedge clk); #1;
         seen = mem_req && mem_we;
         waited++;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rst_wb_entered: got req=%b we=%b want 1 1", mem_req, mem_we); end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_drop: got req=%b we=%b want 0 0", mem_req, mem_we); end
      checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_counters: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt); end
      checks++; if (cpu_stall !== 1'b1 || sram_ren !== 1'b1) begin errors++; $display("FAIL rst_idle_lookup: got stall=%b ren=%b want 1 1", cpu_stall, sram_ren); end
      cpu_ren = 1'b0;
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_idle_stall: got %b want 0", cpu_stall); end
      @(negedge clk);
      rst = 1'b0;
      checks++; if (memwen_cycles != mw0 || arr_tag[2] !== 22'd1 || arr_valid[2] !== 1'b1) begin
         errors++; $display("FAIL rst_no_install: got memWen=%0d tag=%h want 0 1", memwen_cycles - mw0, arr_tag[2]); end
      do_access(1'b1, 1'b0, 32'h440, 32'h0, 4'h0, st, rd, ba);
      checks++; if (st != 0 || rd !== 32'h12345678 || hit_cnt !== 32'd1) begin
         errors++; $display("FAIL rst_after_hit: got stall=%0d data=%h hit=%0d want 0 12345678 1", st, rd, hit_cnt); end
   endtask

   initial begin
      test_reset();
      test_cold_store();
      test_load_hit();
      test_byte_store();
      test_writeback();
      test_long_refill();
      test_back_to_back();
      test_stray_ack();
      test_reset_mid_wb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
